riscvbc_mem_responder: RTL and testbench
========================================

// Module: riscvbc_mem_responder
// PURPOSE
//  Single-port, memory-side responder for the cache-to-memory val/rdy protocol.
//  Accepts VC_MEM_REQ messages from a cache port and returns VC_MEM_RESP messages.
//  Serves as the backing store in riscvbc simulators and cache test benches.
//  It has a fixed, programmable latency and pipelined throughput of one request per cycle.
// PARAMETERS
//  p_mem_sz   1<<20  storage size in bytes (power of 2); word array m[0:p_mem_sz/4-1]
//  p_addr_sz  32     request address width
//  p_data_sz  32     data width (only 32 supported)
//  p_latency  2      cycles from request accept to earliest memresp_val (1..8)
// PORTS
//  clk           in   1   clock
//  reset         in   1   asynchronous, active-high reset
//  memreq_val    in   1   request valid
//  memreq_rdy    out  1   request ready
//  memreq_msg    in   67  {type[66], addr[65:34], len[33:32], data[31:0]}
//  memresp_val   out  1   response valid
//  memresp_rdy   in   1   response ready
//  memresp_msg   out  35  {type[34], len[33:32], data[31:0]}
// BEHAVIOUR
//  - Reset (async): memreq_rdy=0, memresp_val=0, memresp_msg=0.
//    Pipeline valids, queue and outstanding counter are cleared.
//    Storage m is NOT reset; it is loaded by $readmemh via hierarchy <inst>.m.
//  - Reset mid-operation drops all in-flight and queued responses; no partial response is emitted.
//  - A request is accepted at the posedge where memreq_val & memreq_rdy.
//    A response is consumed at the posedge where memresp_val & memresp_rdy.
//  - Type: 0=read, 1=write. len: 0=4 bytes, 1/2/3 = that many bytes.
//  - Word index = addr[log2(p_mem_sz)-1:2]. High address bits are truncated, so accesses wrap.
//    Byte offset off = addr[1:0].
//  - Write: byte lanes off..off+nbytes-1 are updated at the accept edge.
//    Lanes beyond 3 are dropped; an access never crosses a word.
//    Response data = 0.
//  - Read: the word is sampled at the accept edge and shifted right by 8*off.
//    Bytes beyond nbytes are zeroed (zero-extend).
//  - Responses echo the request type and len.
//  - Read-after-write: a read accepted in any cycle after a write sees the written data.
//  - Ordering: responses are strictly in request order.
//  - Latency: a request accepted at edge N with an empty queue gives memresp_val=1
//    after edge N+p_latency-1.
//  - Pipeline: p_latency-1 valid/data stages feed a response queue of depth p_latency+1.
//  - Flow control: an outstanding counter (0..p_latency+1) tracks accepted-but-not-consumed responses.
//    memreq_rdy = !reset & (outstanding < p_latency+1), so the queue never overflows.
//    Accept and consume in the same cycle leave the count unchanged.
//  - Throughput: with memresp_rdy held at 1, one request is accepted every cycle indefinitely.
//  - Backpressure: if memresp_rdy=0, the head response stays stable (val and msg unchanged)
//    until consumed. Once outstanding hits p_latency+1, memreq_rdy drops.
//    memreq_rdy recovers the cycle after a consume.
//  - memresp_msg = 0 whenever memresp_val=0.
//  - Simulation checks: $display error on a memreq_msg X while memreq_val=1.
// STRUCTURE
//  - Shared header vc-MemReqMsg.v: field-position macros, VC_MEM_REQ_MSG_SZ / VC_MEM_RESP_MSG_SZ,
//    type constants c_read=1'b0 / c_write=1'b1, and the len encoding.
//  - Sub-module riscvbc_mem_resp_queue: parameterised depth, 35-bit entries, val/rdy in/out,
//    async reset, and full/empty flags.
//  - Top level holds storage, lane-mask/shift logic, latency pipeline and outstanding counter.
// TESTING (p_latency=2 unless noted; memresp_rdy=1 unless noted)
//  1. Reset: hold reset, then release.
//     -> memresp_val=0 and memreq_rdy=0 during reset; memreq_rdy=1 on the first cycle after.
//  2. Write then read word 0x1000 with data 0xdeadbeef, len=0.
//     -> write response {1,0,0}; read response {0,0,0xdeadbeef}, valid 2 cycles after its accept.
//  3. Byte write at 0x1002 (len=1, data 0xAA) over word 0x11223344, then read at 0x1001 with len=2.
//     -> read returns 0x0000AA33.
//  4. 8 back-to-back reads of preloaded words.
//     -> memreq_rdy stays 1; 8 in-order responses on 8 consecutive cycles.
//  5. Hold memresp_rdy=0 while issuing reads.
//     -> exactly 3 requests accepted, then memreq_rdy=0; the head message is stable.
//     Raise memresp_rdy -> 3 responses drain in order, and memreq_rdy returns the cycle after the first consume.
//  6. Assert reset with 2 reads in flight.
//     -> memresp_val=0 immediately (async); no stale response after release.
//     Memory contents are intact on re-read.
//     Run the same with p_latency=1: response valid 1 cycle after accept.

Source files
------------

// File: rtl/riscvbc_mem_responder_pkg.sv
// Shared message layout, type/len encodings and lane helpers for the
// cache-to-memory val/rdy protocol.
package riscvbc_mem_responder_pkg;

  localparam int unsigned VC_MEM_REQ_MSG_SZ  = 67;
  localparam int unsigned VC_MEM_RESP_MSG_SZ = 35;

  localparam logic c_read  = 1'b0;
  localparam logic c_write = 1'b1;

  // len encoding: 0 = full word, 1..3 = that many bytes
  localparam logic [1:0] c_len_word = 2'd0;

  typedef struct packed {
    logic        typ;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_t;

  typedef struct packed {
    logic        typ;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_t;

  // Byte-lane mask for an access of the given len, anchored at lane 0
  function automatic logic [3:0] len_lanes(input logic [1:0] len);
    case (len)
      c_len_word: return 4'hf;
      2'd1:       return 4'h1;
      2'd2:       return 4'h3;
      default:    return 4'h7;
    endcase
  endfunction

  function automatic logic [31:0] lanes_to_bits(input logic [3:0] lanes);
    logic [31:0] bits;
    for (int i = 0; i < 4; i++) bits[8*i +: 8] = {8{lanes[i]}};
    return bits;
  endfunction

endpackage

// File: rtl/riscvbc_mem_responder_if.sv
// Request/response val/rdy bundle between a cache port and the memory responder.
interface riscvbc_mem_responder_if;
  import riscvbc_mem_responder_pkg::*;

  logic      memreq_val;
  logic      memreq_rdy;
  mem_req_t  memreq_msg;
  logic      memresp_val;
  logic      memresp_rdy;
  mem_resp_t memresp_msg;

  modport master (
    output memreq_val, memreq_msg, memresp_rdy,
    input  memreq_rdy, memresp_val, memresp_msg
  );

  modport slave (
    input  memreq_val, memreq_msg, memresp_rdy,
    output memreq_rdy, memresp_val, memresp_msg
  );

endinterface

// File: rtl/riscvbc_mem_resp_queue.sv
// In-order response FIFO; the head message reads as zero while empty.
module riscvbc_mem_resp_queue #(
  parameter int unsigned p_depth = 3,
  parameter int unsigned p_width = 35
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_width-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_width-1:0] deq_msg,
  output logic               full,
  output logic               empty
);

  localparam int unsigned PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned CW = $clog2(p_depth + 1);

  logic [p_width-1:0] entries [p_depth];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               do_enq;
  logic               do_deq;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(p_depth));
  assign empty   = (count == '0);
  assign enq_rdy = !full;
  assign deq_val = !empty;
  assign deq_msg = empty ? '0 : entries[rd_ptr];
  assign do_enq  = enq_val && !full;
  assign do_deq  = deq_rdy && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wrap_inc(wr_ptr);
      if (do_deq) rd_ptr <= wrap_inc(rd_ptr);
      if (do_enq && !do_deq)      count <= count + CW'(1);
      else if (!do_enq && do_deq) count <= count - CW'(1);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (do_enq) entries[wr_ptr] <= enq_msg;
  end

endmodule

// File: rtl/riscvbc_mem_responder.sv
// Single-port memory-side responder: word storage, byte-lane read/write,
// fixed-latency response pipeline and outstanding-count flow control.
module riscvbc_mem_responder
  import riscvbc_mem_responder_pkg::*;
#(
  parameter int unsigned p_mem_sz  = 1 << 20,
  parameter int unsigned p_addr_sz = 32,
  parameter int unsigned p_data_sz = 32,
  parameter int unsigned p_latency = 2
) (
  input logic                     clk,
  input logic                     reset,
  riscvbc_mem_responder_if.slave  bus
);

  localparam int unsigned WORDS = p_mem_sz / 4;
  localparam int unsigned BA_W  = $clog2(p_mem_sz);
  localparam int unsigned IDX_W = BA_W - 2;
  localparam int unsigned QD    = p_latency + 1;
  localparam int unsigned OW    = $clog2(QD + 1);

  logic [p_data_sz-1:0] m [0:WORDS-1];

  mem_req_t             req;
  logic [p_addr_sz-1:0] addr;
  logic [IDX_W-1:0]     idx;
  logic [1:0]           off;
  logic [4:0]           shamt;
  logic [3:0]           wlanes;
  logic [p_data_sz-1:0] wdata_sh;
  logic [p_data_sz-1:0] rword;
  mem_resp_t            resp_c;

  logic                 req_rdy;
  logic                 accept;
  logic                 consume;
  logic [OW-1:0]        outstanding;

  logic                 q_enq_val;
  mem_resp_t            q_enq_msg;
  logic                 q_enq_rdy;
  logic                 q_deq_val;
  logic [VC_MEM_RESP_MSG_SZ-1:0] q_deq_msg;
  logic                 q_full;
  logic                 q_empty;

  assign req      = bus.memreq_msg;
  assign addr     = p_addr_sz'(req.addr);
  assign idx      = addr[BA_W-1:2];
  assign off      = addr[1:0];
  assign shamt    = {off, 3'b000};
  assign wlanes   = len_lanes(req.len) << off;
  assign wdata_sh = p_data_sz'(req.data) << shamt;
  assign rword    = m[idx];

  assign req_rdy  = !reset && (outstanding < OW'(QD));
  assign accept   = bus.memreq_val && req_rdy;
  assign consume  = q_deq_val && bus.memresp_rdy;

  // Lanes past byte 3 fall off the shift, so an access never spills into the next word
  always_ff @(posedge clk) begin
    if (accept && req.typ == c_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wlanes[i]) m[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  always_comb begin
    resp_c      = '0;
    resp_c.typ  = req.typ;
    resp_c.len  = req.len;
    if (req.typ == c_read)
      resp_c.data = 32'((rword >> shamt) & lanes_to_bits(len_lanes(req.len)));
  end

  // Latency stages ahead of the queue; latency 1 writes the queue at the accept edge
  if (p_latency == 1) begin : g_direct
    assign q_enq_val = accept;
    assign q_enq_msg = resp_c;
  end else begin : g_pipe
    localparam int unsigned NS = p_latency - 1;
    logic [NS-1:0] pv;
    mem_resp_t     pm [NS];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pv <= '0;
      end else begin
        pv[0] <= accept;
        for (int i = 1; i < int'(NS); i++) pv[i] <= pv[i-1];
      end
    end

    always_ff @(posedge clk) begin
      pm[0] <= resp_c;
      for (int i = 1; i < int'(NS); i++) pm[i] <= pm[i-1];
    end

    assign q_enq_val = pv[NS-1];
    assign q_enq_msg = pm[NS-1];
  end

  riscvbc_mem_resp_queue #(
    .p_depth (QD),
    .p_width (VC_MEM_RESP_MSG_SZ)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (q_enq_val),
    .enq_rdy (q_enq_rdy),
    .enq_msg (q_enq_msg),
    .deq_val (q_deq_val),
    .deq_rdy (bus.memresp_rdy),
    .deq_msg (q_deq_msg),
    .full    (q_full),
    .empty   (q_empty)
  );

  // Counting accepted-but-unconsumed responses keeps the queue from overflowing
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   outstanding <= '0;
    else if (accept && !consume) outstanding <= outstanding + OW'(1);
    else if (!accept && consume) outstanding <= outstanding - OW'(1);
  end

  assign bus.memreq_rdy  = req_rdy;
  assign bus.memresp_val = q_deq_val;
  assign bus.memresp_msg = q_deq_msg;

  logic unused_bits;
  assign unused_bits = &{1'b0, addr[p_addr_sz-1:BA_W], q_enq_rdy, q_full, q_empty};

  a_req_known : assert property (@(posedge clk) disable iff (reset)
    bus.memreq_val |-> !$isunknown(bus.memreq_msg));

endmodule

// File: tb/tb_riscvbc_mem_responder.sv
// Directed bench for riscvbc_mem_responder at latency 2 (dut_a) and latency 1 (dut_b).
module tb_riscvbc_mem_responder;
  import riscvbc_mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  riscvbc_mem_responder_if ifa ();
  riscvbc_mem_responder_if ifb ();

  riscvbc_mem_responder #(.p_latency(2)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa.slave));
  riscvbc_mem_responder #(.p_latency(1)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb.slave));

  function automatic mem_req_t mk_req(input logic t, input logic [31:0] a, input logic [1:0] l,
                                      input logic [31:0] d);
    mem_req_t r;
    r.typ = t; r.addr = a; r.len = l; r.data = d;
    return r;
  endfunction

  function automatic mem_resp_t mk_resp(input logic t, input logic [1:0] l, input logic [31:0] d);
    mem_resp_t r;
    r.typ = t; r.len = l; r.data = d;
    return r;
  endfunction

  task automatic drive(input bit sel, input logic v, input mem_req_t msg);
    if (sel) begin ifb.memreq_val = v; ifb.memreq_msg = msg; end
    else     begin ifa.memreq_val = v; ifa.memreq_msg = msg; end
  endtask

  task automatic set_resp_rdy(input bit sel, input logic r);
    if (sel) ifb.memresp_rdy = r; else ifa.memresp_rdy = r;
  endtask

  function automatic logic req_rdy(input bit sel);
    return sel ? ifb.memreq_rdy : ifa.memreq_rdy;
  endfunction

  function automatic logic resp_val(input bit sel);
    return sel ? ifb.memresp_val : ifa.memresp_val;
  endfunction

  function automatic mem_resp_t resp_msg(input bit sel);
    return sel ? ifb.memresp_msg : ifa.memresp_msg;
  endfunction

  // One request end to end; lat = edges from the accept edge until memresp_val is seen
  task automatic do_req(input bit sel, input mem_req_t r, output mem_resp_t got,
                        output int lat, output bit ok);
    int n;
    ok = 1'b0; lat = -1; got = '0; n = 0;
    set_resp_rdy(sel, 1'b1);
    drive(sel, 1'b1, r);
    while (!req_rdy(sel) && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_rdy(sel)) begin drive(sel, 1'b0, '0); return; end
    @(posedge clk); #1;
    drive(sel, 1'b0, '0);
    lat = 0;
    while (!resp_val(sel) && lat < 20) begin @(posedge clk); #1; lat++; end
    if (resp_val(sel)) begin ok = 1'b1; got = resp_msg(sel); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    drive(0, 1'b0, '0); drive(1, 1'b0, '0);
    set_resp_rdy(0, 1'b0); set_resp_rdy(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ifa.memresp_val !== 1'b0) begin n_fail++; $display("FAIL reset_resp_val got=%b want=0", ifa.memresp_val); end
    n_checks++; if (ifa.memreq_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_req_rdy got=%b want=0", ifa.memreq_rdy); end
    n_checks++; if (ifa.memresp_msg !== 35'h0) begin n_fail++; $display("FAIL reset_resp_msg got=%h want=0", ifa.memresp_msg); end
    n_checks++; if (ifb.memreq_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_req_rdy_b got=%b want=0", ifb.memreq_rdy); end
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ifa.memreq_rdy !== 1'b1) begin n_fail++; $display("FAIL post_reset_req_rdy got=%b want=1", ifa.memreq_rdy); end
    n_checks++; if (ifa.memresp_val !== 1'b0) begin n_fail++; $display("FAIL post_reset_resp_val got=%b want=0", ifa.memresp_val); end
  endtask

  task automatic test_write_read();
    set_resp_rdy(0, 1'b1);
    drive(0, 1'b1, mk_req(c_write, 32'h1000, 2'd0, 32'hdeadbeef));
    n_checks++; if (ifa.memreq_rdy !== 1'b1) begin n_fail++; $display("FAIL wr_req_rdy got=%b want=1", ifa.memreq_rdy); end
    @(posedge clk); #1;
    n_checks++; if (ifa.memresp_val !== 1'b0) begin n_fail++; $display("FAIL wr_early_val got=%b want=0", ifa.memresp_val); end
    drive(0, 1'b1, mk_req(c_read, 32'h1000, 2'd0, 32'h0));
    @(posedge clk); #1;
    drive(0, 1'b0, '0);
    n_checks++; if (ifa.memresp_val !== 1'b1) begin n_fail++; $display("FAIL wr_resp_val got=%b want=1", ifa.memresp_val); end
    n_checks++; if (ifa.memresp_msg !== mk_resp(c_write, 2'd0, 32'h0)) begin n_fail++; $display("FAIL wr_resp_msg got=%h want=%h", ifa.memresp_msg, mk_resp(c_write, 2'd0, 32'h0)); end
    @(posedge clk); #1;
    n_checks++; if (ifa.memresp_val !== 1'b1) begin n_fail++; $display("FAIL rd_resp_val got=%b want=1", ifa.memresp_val); end
    n_checks++; if (ifa.memresp_msg !== mk_resp(c_read, 2'd0, 32'hdeadbeef)) begin n_fail++; $display("FAIL rd_resp_msg got=%h want=%h", ifa.memresp_msg, mk_resp(c_read, 2'd0, 32'hdeadbeef)); end
    @(posedge clk); #1;
    n_checks++; if (ifa.memresp_val !== 1'b0) begin n_fail++; $display("FAIL idle_val got=%b want=0", ifa.memresp_val); end
    n_checks++; if (ifa.memresp_msg !== 35'h0) begin n_fail++; $display("FAIL idle_msg got=%h want=0", ifa.memresp_msg); end
  endtask

  task automatic test_byte_lanes();
    mem_req_t  reqs [8];
    mem_resp_t exps [8];
    mem_resp_t got;
    int        lat;
    bit        ok;
    reqs[0] = mk_req(c_write, 32'h1000,   2'd0, 32'h11223344); exps[0] = mk_resp(c_write, 2'd0, 32'h0);
    reqs[1] = mk_req(c_write, 32'h1002,   2'd1, 32'h000000aa); exps[1] = mk_resp(c_write, 2'd1, 32'h0);
    reqs[2] = mk_req(c_read,  32'h1001,   2'd2, 32'h0);        exps[2] = mk_resp(c_read,  2'd2, 32'h0000aa33);
    reqs[3] = mk_req(c_read,  32'h1003,   2'd1, 32'h0);        exps[3] = mk_resp(c_read,  2'd1, 32'h00000011);
    reqs[4] = mk_req(c_write, 32'h1003,   2'd2, 32'h0000bbcc); exps[4] = mk_resp(c_write, 2'd2, 32'h0);
    reqs[5] = mk_req(c_read,  32'h1000,   2'd0, 32'h0);        exps[5] = mk_resp(c_read,  2'd0, 32'hccaa3344);
    reqs[6] = mk_req(c_read,  32'h101000, 2'd0, 32'h0);        exps[6] = mk_resp(c_read,  2'd0, 32'hccaa3344);
    reqs[7] = mk_req(c_read,  32'h1002,   2'd3, 32'h0);        exps[7] = mk_resp(c_read,  2'd3, 32'h0000ccaa);
    for (int i = 0; i < 8; i++) begin
      do_req(0, reqs[i], got, lat, ok);
      n_checks++; if (!ok || got !== exps[i]) begin n_fail++; $display("FAIL lanes[%0d] got=%h ok=%0d want=%h", i, got, ok, exps[i]); end
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL lanes_lat[%0d] got=%0d want=1", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    mem_resp_t got;
    int lat, k, nresp, first_c, last_c, rdy_low;
    bit ok, acc;
    for (int i = 0; i < 8; i++) do_req(0, mk_req(c_write, 32'h2000 + 32'(4*i), 2'd0, 32'ha5000000 + 32'(i)), got, lat, ok);
    k = 0; nresp = 0; first_c = -1; last_c = -1; rdy_low = 0;
    set_resp_rdy(0, 1'b1);
    for (int c = 0; c < 14; c++) begin
      if (k < 8) drive(0, 1'b1, mk_req(c_read, 32'h2000 + 32'(4*k), 2'd0, 32'h0));
      else       drive(0, 1'b0, '0);
      acc = (k < 8) && ifa.memreq_rdy;
      if (k < 8 && !ifa.memreq_rdy) rdy_low++;
      @(posedge clk); #1;
      if (acc) k++;
      if (ifa.memresp_val) begin
        n_checks++; if (ifa.memresp_msg !== mk_resp(c_read, 2'd0, 32'ha5000000 + 32'(nresp))) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h want=%h", nresp, ifa.memresp_msg, mk_resp(c_read, 2'd0, 32'ha5000000 + 32'(nresp))); end
        if (first_c < 0) first_c = c;
        last_c = c;
        nresp++;
      end
    end
    drive(0, 1'b0, '0);
    n_checks++; if (rdy_low !== 0) begin n_fail++; $display("FAIL b2b_rdy_low got=%0d want=0", rdy_low); end
    n_checks++; if (nresp !== 8) begin n_fail++; $display("FAIL b2b_count got=%0d want=8", nresp); end
    n_checks++; if (first_c !== 1 || last_c !== 8) begin n_fail++; $display("FAIL b2b_window got=%0d..%0d want=1..8", first_c, last_c); end
  endtask

  task automatic test_backpressure();
    int  nacc;
    bit  acc;
    nacc = 0;
    set_resp_rdy(0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      drive(0, 1'b1, mk_req(c_read, 32'h2000 + 32'(4*nacc), 2'd0, 32'h0));
      acc = ifa.memreq_rdy;
      @(posedge clk); #1;
      if (acc) nacc++;
      if (c >= 1) begin
        n_checks++; if (ifa.memresp_val !== 1'b1 || ifa.memresp_msg !== mk_resp(c_read, 2'd0, 32'ha5000000)) begin n_fail++; $display("FAIL bp_head[%0d] got=%b/%h want=1/%h", c, ifa.memresp_val, ifa.memresp_msg, mk_resp(c_read, 2'd0, 32'ha5000000)); end
      end
    end
    drive(0, 1'b0, '0);
    n_checks++; if (nacc !== 3) begin n_fail++; $display("FAIL bp_accepts got=%0d want=3", nacc); end
    n_checks++; if (ifa.memreq_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_req_rdy got=%b want=0", ifa.memreq_rdy); end
    set_resp_rdy(0, 1'b1);
    @(posedge clk); #1;
    n_checks++; if (ifa.memreq_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_recover got=%b want=1", ifa.memreq_rdy); end
    n_checks++; if (ifa.memresp_msg !== mk_resp(c_read, 2'd0, 32'ha5000001)) begin n_fail++; $display("FAIL bp_drain1 got=%h want=%h", ifa.memresp_msg, mk_resp(c_read, 2'd0, 32'ha5000001)); end
    @(posedge clk); #1;
    n_checks++; if (ifa.memresp_msg !== mk_resp(c_read, 2'd0, 32'ha5000002)) begin n_fail++; $display("FAIL bp_drain2 got=%h want=%h", ifa.memresp_msg, mk_resp(c_read, 2'd0, 32'ha5000002)); end
    @(posedge clk); #1;
    n_checks++; if (ifa.memresp_val !== 1'b0) begin n_fail++; $display("FAIL bp_drained got=%b want=0", ifa.memresp_val); end
  endtask

  task automatic test_reset_inflight();
    mem_resp_t got;
    int lat, stale;
    bit ok;
    set_resp_rdy(0, 1'b1);
    drive(0, 1'b1, mk_req(c_read, 32'h2000, 2'd0, 32'h0));
    @(posedge clk); #1;
    drive(0, 1'b1, mk_req(c_read, 32'h2004, 2'd0, 32'h0));
    @(posedge clk); #1;
    drive(0, 1'b0, '0);
    n_checks++; if (ifa.memresp_val !== 1'b1) begin n_fail++; $display("FAIL rst_pre_val got=%b want=1", ifa.memresp_val); end
    rst_a = 1'b1;
    #1;
    n_checks++; if (ifa.memresp_val !== 1'b0 || ifa.memresp_msg !== 35'h0) begin n_fail++; $display("FAIL rst_async got=%b/%h want=0/0", ifa.memresp_val, ifa.memresp_msg); end
    n_checks++; if (ifa.memreq_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_req_rdy got=%b want=0", ifa.memreq_rdy); end
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      if (ifa.memresp_val) stale++;
      @(posedge clk); #1;
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL rst_stale got=%0d want=0", stale); end
    do_req(0, mk_req(c_read, 32'h2004, 2'd0, 32'h0), got, lat, ok);
    n_checks++; if (!ok || got !== mk_resp(c_read, 2'd0, 32'ha5000001)) begin n_fail++; $display("FAIL rst_reread0 got=%h want=%h", got, mk_resp(c_read, 2'd0, 32'ha5000001)); end
    do_req(0, mk_req(c_read, 32'h1000, 2'd0, 32'h0), got, lat, ok);
    n_checks++; if (!ok || got !== mk_resp(c_read, 2'd0, 32'hccaa3344)) begin n_fail++; $display("FAIL rst_reread1 got=%h want=%h", got, mk_resp(c_read, 2'd0, 32'hccaa3344)); end
  endtask

  task automatic test_latency1();
    mem_resp_t got;
    int lat, nacc;
    bit ok, acc;
    do_req(1, mk_req(c_write, 32'h40, 2'd0, 32'h12345678), got, lat, ok);
    n_checks++; if (!ok || got !== mk_resp(c_write, 2'd0, 32'h0) || lat !== 0) begin n_fail++; $display("FAIL l1_write got=%h lat=%0d want=%h lat=0", got, lat, mk_resp(c_write, 2'd0, 32'h0)); end
    do_req(1, mk_req(c_read, 32'h40, 2'd0, 32'h0), got, lat, ok);
    n_checks++; if (!ok || got !== mk_resp(c_read, 2'd0, 32'h12345678) || lat !== 0) begin n_fail++; $display("FAIL l1_read got=%h lat=%0d want=%h lat=0", got, lat, mk_resp(c_read, 2'd0, 32'h12345678)); end
    do_req(1, mk_req(c_read, 32'h42, 2'd1, 32'h0), got, lat, ok);
    n_checks++; if (!ok || got !== mk_resp(c_read, 2'd1, 32'h34)) begin n_fail++; $display("FAIL l1_byte got=%h want=%h", got, mk_resp(c_read, 2'd1, 32'h34)); end
    nacc = 0;
    set_resp_rdy(1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      drive(1, 1'b1, mk_req(c_read, 32'h40, 2'd0, 32'h0));
      acc = ifb.memreq_rdy;
      @(posedge clk); #1;
      if (acc) nacc++;
    end
    drive(1, 1'b0, '0);
    n_checks++; if (nacc !== 2 || ifb.memreq_rdy !== 1'b0) begin n_fail++; $display("FAIL l1_bp got=%0d/%b want=2/0", nacc, ifb.memreq_rdy); end
    set_resp_rdy(1, 1'b1);
    @(posedge clk); #1;
    n_checks++; if (ifb.memreq_rdy !== 1'b1 || ifb.memresp_msg !== mk_resp(c_read, 2'd0, 32'h12345678)) begin n_fail++; $display("FAIL l1_drain got=%b/%h want=1/%h", ifb.memreq_rdy, ifb.memresp_msg, mk_resp(c_read, 2'd0, 32'h12345678)); end
    @(posedge clk); #1;
    n_checks++; if (ifb.memresp_val !== 1'b0) begin n_fail++; $display("FAIL l1_drained got=%b want=0", ifb.memresp_val); end
    set_resp_rdy(1, 1'b0);
    drive(1, 1'b1, mk_req(c_read, 32'h40, 2'd0, 32'h0));
    @(posedge clk); #1;
    drive(1, 1'b0, '0);
    rst_b = 1'b1;
    #1;
    n_checks++; if (ifb.memresp_val !== 1'b0) begin n_fail++; $display("FAIL l1_rst_async got=%b want=0", ifb.memresp_val); end
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ifb.memresp_val !== 1'b0) begin n_fail++; $display("FAIL l1_rst_stale got=%b want=0", ifb.memresp_val); end
    do_req(1, mk_req(c_read, 32'h40, 2'd0, 32'h0), got, lat, ok);
    n_checks++; if (!ok || got !== mk_resp(c_read, 2'd0, 32'h12345678)) begin n_fail++; $display("FAIL l1_reread got=%h want=%h", got, mk_resp(c_read, 2'd0, 32'h12345678)); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    test_latency1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t limit=100000", $time);
    $fatal(1);
  end

endmodule
